// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Merges NUM_PORTS memory requesters onto a single memory port. A requester
// is picked combinationally (round-robin or fixed priority). Its request is
// forwarded with zero latency. The index of every accepted request is pushed
// into an in-order ID FIFO, so each downstream response can be steered back
// to the port that issued it.
//
// Parameters
//   NUM_PORTS       number of requester ports (>= 2)
//   XLEN            address / data width
//   MAX_OUTSTANDING depth of the in-flight ID FIFO (power of two, >= 1)
//   ARB_MODE        0 = round-robin, 1 = fixed priority (port 0 highest)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     per-port request handshake
//   req_addr/data       per-port address and write data, port i at [i*XLEN +: XLEN]
//   req_fcn/typ         per-port write signal (2b) and mask type (3b)
//   res_valid           one-hot response strobe to the issuing port
//   res_data            response data, broadcast to all ports
//   mem_req_*           muxed downstream request
//   mem_res_valid/data  downstream response
//   outstanding         number of in-flight requests
//   err_unexpected_res  sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS*XLEN-1:0]             req_addr,
  input  logic [NUM_PORTS*XLEN-1:0]             req_data,
  input  logic [NUM_PORTS*2-1:0]                req_fcn,
  input  logic [NUM_PORTS*3-1:0]                req_typ,
  output logic [NUM_PORTS-1:0]                  res_valid,
  output logic [XLEN-1:0]                       res_data,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic [XLEN-1:0]                       mem_req_addr,
  output logic [XLEN-1:0]                       mem_req_data,
  output logic [1:0]                            mem_req_fcn,
  output logic [2:0]                            mem_req_typ,
  input  logic                                  mem_res_valid,
  input  logic [XLEN-1:0]                       mem_res_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
  output logic                                  err_unexpected_res
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [ID_W-1:0]  LAST_PORT = ID_W'(NUM_PORTS - 1);

  // State
  logic [ID_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [ID_W-1:0]  r_id_fifo [MAX_OUTSTANDING];

  // Combinational
  logic                 w_sel_any;
  logic [ID_W-1:0]      w_sel_idx;
  logic                 w_slot_ok;
  logic                 w_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [ID_W-1:0]      w_head_id;
  logic [NUM_PORTS-1:0] w_res_valid;
  logic [NUM_PORTS-1:0] w_req_ready;

  // (base + k) mod NUM_PORTS, with k in [0, NUM_PORTS)
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return ID_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Requester selection. Scanning from the far end down to the preferred
  // end lets the last hit win, so no early loop exit is needed.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so
    // that no path through the block leaves it unassigned (no latch).
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          w_sel_any = 1'b1;
          w_sel_idx = ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(r_rr_ptr, k)]) begin
          w_sel_any = 1'b1;
          w_sel_idx = wrap_add(r_rr_ptr, k);
        end
      end
    end
  end

  // A response popping this cycle frees a slot for a same-cycle push.
  assign w_slot_ok = (r_count < MAX_CNT) || mem_res_valid;

  // mem_req_valid is built without mem_req_ready so that a downstream
  // ready that depends on valid cannot form a combinational loop.
  assign mem_req_valid = w_sel_any && w_slot_ok;
  assign w_fire        = mem_req_valid && mem_req_ready;
  assign w_push        = w_fire;
  assign w_pop         = mem_res_valid && (r_count != '0);
  assign w_head_id     = r_id_fifo[r_rd_ptr];

  assign mem_req_addr = w_sel_any ? req_addr[w_sel_idx*XLEN +: XLEN] : '0;
  assign mem_req_data = w_sel_any ? req_data[w_sel_idx*XLEN +: XLEN] : '0;
  assign mem_req_fcn  = w_sel_any ? req_fcn[w_sel_idx*2 +: 2]        : '0;
  assign mem_req_typ  = w_sel_any ? req_typ[w_sel_idx*3 +: 3]        : '0;

  always_comb begin
    w_req_ready = '0;
    w_res_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req_ready[i] = w_fire && (w_sel_idx == ID_W'(i));
      w_res_valid[i] = w_pop  && (w_head_id == ID_W'(i));
    end
  end

  assign req_ready          = w_req_ready;
  assign res_valid          = w_res_valid;
  assign res_data           = mem_res_data;
  assign outstanding        = r_count;
  assign err_unexpected_res = r_err;

  // Control state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, whatever the statement order.
    if (reset) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_fire && (ARB_MODE == 0))
        r_rr_ptr <= (w_sel_idx == LAST_PORT) ? '0 : w_sel_idx + 1'b1;
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing in flight is dropped and flagged until reset.
      if (mem_res_valid && (r_count == '0))
        r_err <= 1'b1;
    end
  end

  // ID storage
  // NOTE: the FIFO array is deliberately not reset; entries are only read
  // between a push and its pop, so the pointers and count alone define
  // validity and the array can map onto plain storage.
  always_ff @(posedge clk) begin
    if (w_push) r_id_fifo[r_wr_ptr] <= w_sel_idx;
  end

endmodule
